dmem_arbiter: RTL and testbench

- Shares the single-ported data memory between two requesters: the CPU MEM stage and a DMA/peripheral requester, such as the audio sample streamer.
- CPU has priority by default. A starvation counter guarantees the DMA a slot after MAX_WAIT lost arbitrations.
- Sequences multi-cycle reads, stalls the CPU pipeline while its access is pending, and returns read data with a valid strobe.

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/dmem_starve_cnt.sv | 37 +++
 rtl/dmem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter:
//   state_t  - arbiter FSM states (IDLE, RD_WAIT, RD_RET)
//   owner_t  - which requester owns an in-flight read
//   DATA_W   - default address/data width
//   starve_w - width needed to count lost DMA arbitrations up to MAX_WAIT
package dmem_arb_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RET  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Bits required to hold 0..max_wait inclusive.
  function automatic int starve_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_starve_cnt.sv
// dmem_starve_cnt
// Saturating counter of consecutive arbitrations lost by the DMA requester.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   inc   in  DMA lost an arbitration this cycle
//   clr   in  DMA was granted this cycle (takes precedence over inc)
//   sat   out counter has reached MAX_WAIT; the DMA must win next
module dmem_starve_cnt #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt;

  assign sat = (cnt == CNT_W'(MAX_WAIT));

  // Count lost arbitrations, clear on grant, hold once saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates the single-ported data memory between the CPU MEM stage and a
// DMA requester. CPU has priority; after MAX_WAIT consecutive lost
// arbitrations the DMA is forced to win. Writes complete in the issue cycle;
// reads run IDLE -> RD_WAIT (RD_LAT cycles) -> RD_RET (rvalid pulse) -> IDLE.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request (held until complete)
//   cpu_stall                     combinational pipeline freeze
//   cpu_rdata, cpu_rvalid         registered CPU read return
//   dma_req/we/addr/wdata         DMA request (held until dma_gnt)
//   dma_gnt                       combinational DMA accept strobe
//   dma_rdata, dma_rvalid         registered DMA read return
//   mem_addr/wdata/we/re          memory command from the arbitration winner
//   mem_rdata                     memory data, valid RD_LAT cycles after mem_re
//   perf_cpu_stall_cycles         stall-cycle counter (0 unless DMEM_ARB_PERF_EN)
//   perf_dma_grants               DMA grant counter   (0 unless DMEM_ARB_PERF_EN)
// Build option: define DMEM_ARB_PERF_EN to instantiate the performance counters.
module dmem_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4,
  parameter int DATA_W   = dmem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_cpu_stall_cycles,
  output logic [31:0]       perf_dma_grants
);

  import dmem_arb_pkg::*;

  localparam int STARVE_W = starve_w(MAX_WAIT);
  localparam int LAT_W    = 3;

  state_t           state;
  state_t           state_next;
  owner_t           owner;
  logic [LAT_W-1:0] lat_cnt;

  logic idle;
  logic force_dma;
  logic dma_win;
  logic cpu_win;
  logic rd_issue;
  logic starve_inc;

  dmem_starve_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (STARVE_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (dma_win),
    .sat   (force_dma)
  );

  // Arbitration: only in IDLE and never while reset is held, so reset
  // forces every combinational command/grant low.
  always_comb begin
    idle    = (state == IDLE) && !reset;
    dma_win = 1'b0;
    cpu_win = 1'b0;
    if (idle) begin
      if (dma_req && (!cpu_req || force_dma)) begin
        dma_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else begin
        dma_win = 1'b0;
        cpu_win = 1'b0;
      end
    end else begin
      dma_win = 1'b0;
      cpu_win = 1'b0;
    end
    rd_issue   = (dma_win && !dma_we) || (cpu_win && !cpu_we);
    starve_inc = cpu_win && dma_req;
  end

  // Memory command mux driven by the current winner.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (dma_win) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
      mem_re    = !dma_we;
    end else if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = !cpu_we;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
    end
  end

  // Handshakes: the CPU is released by its own write issue or its rvalid.
  always_comb begin
    dma_gnt   = dma_win;
    cpu_stall = cpu_req && !(cpu_win && cpu_we) && !cpu_rvalid;
  end

  // Next-state logic for the read sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rd_issue) begin
          state_next = RD_WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_W'(0)) begin
          state_next = RD_RET;
        end else begin
          state_next = RD_WAIT;
        end
      end
      RD_RET:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read datapath: latch owner and latency on issue, capture data when the
  // latency expires and raise the owner's rvalid for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= OWN_CPU;
      lat_cnt    <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_issue) begin
            owner   <= dma_win ? OWN_DMA : OWN_CPU;
            lat_cnt <= LAT_W'(RD_LAT - 1);
          end
        end
        RD_WAIT: begin
          if (lat_cnt == LAT_W'(0)) begin
            if (owner == OWN_DMA) begin
              dma_rdata  <= mem_rdata;
              dma_rvalid <= 1'b1;
            end else begin
              cpu_rdata  <= mem_rdata;
              cpu_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RD_RET:  lat_cnt <= lat_cnt;
        default: lat_cnt <= '0;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Wrapping performance counters: stalled CPU cycles and DMA grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cpu_stall_cycles <= 32'd0;
      perf_dma_grants       <= 32'd0;
    end else begin
      if (cpu_stall) begin
        perf_cpu_stall_cycles <= perf_cpu_stall_cycles + 32'd1;
      end
      if (dma_gnt) begin
        perf_dma_grants <= perf_dma_grants + 32'd1;
      end
    end
  end
`else
  assign perf_cpu_stall_cycles = 32'd0;
  assign perf_dma_grants       = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. Two instances share one stimulus set:
// u_a uses RD_LAT=1, u_b uses RD_LAT=2 (both MAX_WAIT=4). Each has its own
// behavioural memory whose read data is valid only RD_LAT cycles after mem_re.
module tb_dmem_arbiter;

  import dmem_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [63:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic        a_cpu_stall, a_cpu_rvalid, a_dma_gnt, a_dma_rvalid, a_mem_we, a_mem_re;
  logic [63:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [31:0] a_perf_stall, a_perf_grants;
  logic        b_cpu_stall, b_cpu_rvalid, b_dma_gnt, b_dma_rvalid, b_mem_we, b_mem_re;
  logic [63:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] b_perf_stall, b_perf_grants;

  int checks   = 0;
  int failures = 0;

`ifdef DMEM_ARB_PERF_EN
  localparam logic [63:0] EXP_PERF = 64'd2;
`else
  localparam logic [63:0] EXP_PERF = 64'd0;
`endif

  dmem_arbiter #(.RD_LAT(1), .MAX_WAIT(4), .DATA_W(64)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(a_cpu_stall), .cpu_rdata(a_cpu_rdata), .cpu_rvalid(a_cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(a_dma_gnt), .dma_rdata(a_dma_rdata), .dma_rvalid(a_dma_rvalid),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_re(a_mem_re),
    .mem_rdata(a_mem_rdata),
    .perf_cpu_stall_cycles(a_perf_stall), .perf_dma_grants(a_perf_grants)
  );

  dmem_arbiter #(.RD_LAT(2), .MAX_WAIT(4), .DATA_W(64)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(b_cpu_stall), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(b_dma_gnt), .dma_rdata(b_dma_rdata), .dma_rvalid(b_dma_rvalid),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_rdata(b_mem_rdata),
    .perf_cpu_stall_cycles(b_perf_stall), .perf_dma_grants(b_perf_grants)
  );

  // Memory contents: 0x18 holds 0x1234, everything else addr*3+5.
  function automatic logic [63:0] mem_val(input logic [63:0] addr);
    if (addr == 64'h18) return 64'h1234;
    return addr * 64'd3 + 64'd5;
  endfunction

  logic        a_re_q, b_re_q1, b_re_q2;
  logic [63:0] a_addr_q, b_addr_q1, b_addr_q2;

  // Latency pipelines of the two behavioural memories.
  always @(posedge clk) begin
    a_re_q    <= a_mem_re;
    a_addr_q  <= a_mem_addr;
    b_re_q1   <= b_mem_re;
    b_addr_q1 <= b_mem_addr;
    b_re_q2   <= b_re_q1;
    b_addr_q2 <= b_addr_q1;
  end

  assign a_mem_rdata = a_re_q  ? mem_val(a_addr_q)  : 64'hDEAD_BEEF_DEAD_BEEF;
  assign b_mem_rdata = b_re_q2 ? mem_val(b_addr_q2) : 64'hDEAD_BEEF_DEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A stalled CPU must not change its access while it keeps requesting.
  a_cpu_hold_a: assert property (@(posedge clk) disable iff (reset)
    (cpu_req && a_cpu_stall) |=> (!cpu_req || ($stable(cpu_we) && $stable(cpu_addr) && $stable(cpu_wdata))));
  a_cpu_hold_b: assert property (@(posedge clk) disable iff (reset)
    (cpu_req && b_cpu_stall) |=> (!cpu_req || ($stable(cpu_we) && $stable(cpu_addr) && $stable(cpu_wdata))));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'h0; cpu_wdata = 64'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 64'h0; dma_wdata = 64'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    // Reset with both requesters asserting: all commands suppressed.
    clear_inputs();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; dma_req = 1'b1; dma_we = 1'b1;
    sample();
    check("rst_mem_we",   64'(a_mem_we),     64'd0);
    check("rst_mem_re",   64'(a_mem_re),     64'd0);
    check("rst_dma_gnt",  64'(a_dma_gnt),    64'd0);
    check("rst_stall",    64'(a_cpu_stall),  64'd1);
    check("rst_rvalid",   64'(a_cpu_rvalid), 64'd0);
    check("rst_cpu_rdata", a_cpu_rdata,      64'd0);
    check("rst_perf_grants", 64'(a_perf_grants), 64'd0);
    next_cycle();
    reset = 1'b0;

    // CPU write completes in its issue cycle.
    clear_inputs();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'hAB;
    sample();
    check("wr_mem_we",    64'(a_mem_we),    64'd1);
    check("wr_mem_re",    64'(a_mem_re),    64'd0);
    check("wr_mem_addr",  a_mem_addr,       64'h10);
    check("wr_mem_wdata", a_mem_wdata,      64'hAB);
    check("wr_stall",     64'(a_cpu_stall), 64'd0);
    check("wr_stall_b",   64'(b_cpu_stall), 64'd0);
    next_cycle();
    cpu_req = 1'b0;
    sample();
    check("wr_state_idle", 64'(u_a.state), 64'(IDLE));
    check("wr_done_we",    64'(a_mem_we),  64'd0);
    next_cycle();

    // CPU read of 0x18: A returns at t+2, B at t+3.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h18;
    sample();
    check("rd_t0_stall", 64'(a_cpu_stall), 64'd1);
    check("rd_t0_re",    64'(a_mem_re),    64'd1);
    check("rd_t0_addr",  a_mem_addr,       64'h18);
    next_cycle();
    sample();
    check("rd_t1_stall",  64'(a_cpu_stall),  64'd1);
    check("rd_t1_re",     64'(a_mem_re),     64'd0);
    check("rd_t1_rvalid", 64'(a_cpu_rvalid), 64'd0);
    next_cycle();
    sample();
    check("rd_t2_rvalid", 64'(a_cpu_rvalid), 64'd1);
    check("rd_t2_rdata",  a_cpu_rdata,       64'h1234);
    check("rd_t2_stall",  64'(a_cpu_stall),  64'd0);
    check("rd_t2_stall_b", 64'(b_cpu_stall), 64'd1);
    next_cycle();
    cpu_req = 1'b0;
    sample();
    check("rd_t3_rvalid_pulse", 64'(a_cpu_rvalid), 64'd0);
    check("rd_t3_rvalid_b",     64'(b_cpu_rvalid), 64'd1);
    check("rd_t3_rdata_b",      b_cpu_rdata,       64'h1234);
    next_cycle();
    do_reset();

    // Both requesters writing continuously: 4 CPU grants, then 1 DMA grant.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h20; cpu_wdata = 64'h11;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h40; dma_wdata = 64'h22;
    for (int k = 0; k < 10; k++) begin
      logic g;
      g = ((k % 5) == 4);
      sample();
      check($sformatf("starve_gnt_%0d", k),   64'(a_dma_gnt),   64'(g));
      check($sformatf("starve_stall_%0d", k), 64'(a_cpu_stall), 64'(g));
      check($sformatf("starve_addr_%0d", k),  a_mem_addr,       g ? 64'h40 : 64'h20);
      check($sformatf("starve_cnt_%0d", k),   64'(u_a.u_starve.cnt), 64'(k % 5));
      check($sformatf("starve_gnt_b_%0d", k), 64'(b_dma_gnt),   64'(g));
      next_cycle();
    end
    sample();
    check("perf_grants_a", 64'(a_perf_grants), EXP_PERF);
    check("perf_stall_a",  64'(a_perf_stall),  EXP_PERF);
    check("perf_grants_b", 64'(b_perf_grants), EXP_PERF);
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();

    // Starve counter is saturated: DMA read is forced through (B, RD_LAT=2).
    dma_we = 1'b0; dma_addr = 64'h50;
    sample();
    check("frc_t0_gnt",   64'(b_dma_gnt),   64'd1);
    check("frc_t0_re",    64'(b_mem_re),    64'd1);
    check("frc_t0_we",    64'(b_mem_we),    64'd0);
    check("frc_t0_addr",  b_mem_addr,       64'h50);
    check("frc_t0_stall", 64'(b_cpu_stall), 64'd1);
    next_cycle();
    dma_req = 1'b0;
    sample();
    check("frc_t1_gnt",    64'(b_dma_gnt),    64'd0);
    check("frc_t1_re",     64'(b_mem_re),     64'd0);
    check("frc_t1_we",     64'(b_mem_we),     64'd0);
    check("frc_t1_stall",  64'(b_cpu_stall),  64'd1);
    check("frc_t1_rvalid", 64'(b_dma_rvalid), 64'd0);
    next_cycle();
    sample();
    check("frc_t2_stall",    64'(b_cpu_stall),  64'd1);
    check("frc_t2_rvalid",   64'(b_dma_rvalid), 64'd0);
    check("frc_t2_rvalid_a", 64'(a_dma_rvalid), 64'd1);
    check("frc_t2_rdata_a",  a_dma_rdata,       64'hF5);
    next_cycle();
    sample();
    check("frc_t3_rvalid", 64'(b_dma_rvalid), 64'd1);
    check("frc_t3_rdata",  b_dma_rdata,       64'hF5);
    check("frc_t3_stall",  64'(b_cpu_stall),  64'd1);
    check("frc_t3_we",     64'(b_mem_we),     64'd0);
    next_cycle();
    sample();
    check("frc_t4_we",    64'(b_mem_we),    64'd1);
    check("frc_t4_addr",  b_mem_addr,       64'h20);
    check("frc_t4_stall", 64'(b_cpu_stall), 64'd0);
    next_cycle();
    clear_inputs();
    next_cycle();
    next_cycle();

    // Reset in the middle of a CPU read drops it entirely.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h18;
    sample();
    check("mid_t0_re", 64'(a_mem_re), 64'd1);
    next_cycle();
    reset = 1'b1;
    sample();
    check("mid_rst_re",        64'(a_mem_re),     64'd0);
    check("mid_rst_we",        64'(a_mem_we),     64'd0);
    check("mid_rst_gnt",       64'(a_dma_gnt),    64'd0);
    check("mid_rst_stall",     64'(a_cpu_stall),  64'd1);
    check("mid_rst_rvalid",    64'(a_cpu_rvalid), 64'd0);
    check("mid_rst_cpu_rdata", a_cpu_rdata,       64'd0);
    check("mid_rst_dma_rdata", a_dma_rdata,       64'd0);
    check("mid_rst_perf",      64'(a_perf_stall), 64'd0);
    next_cycle();
    reset = 1'b0;
    cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check($sformatf("mid_no_rvalid_a_%0d", k), 64'(a_cpu_rvalid), 64'd0);
      check($sformatf("mid_no_rvalid_b_%0d", k), 64'(b_cpu_rvalid), 64'd0);
      next_cycle();
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h30; cpu_wdata = 64'h77;
    sample();
    check("post_wr_we",    64'(a_mem_we),    64'd1);
    check("post_wr_addr",  a_mem_addr,       64'h30);
    check("post_wr_stall", 64'(a_cpu_stall), 64'd0);
    next_cycle();
    clear_inputs();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h60;
    sample();
    check("post_dma_gnt", 64'(a_dma_gnt), 64'd1);
    check("post_dma_re",  64'(a_mem_re),  64'd1);
    next_cycle();
    dma_req = 1'b0;
    next_cycle();
    sample();
    check("post_dma_rvalid", 64'(a_dma_rvalid), 64'd1);
    check("post_dma_rdata",  a_dma_rdata,       64'h125);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
